// File: rtl/line_job_sched_pkg.sv
// Shared types for the line-job scheduler: segment record, FSM states, default widths.
package line_job_sched_pkg;

  localparam int LINE_XW = 11;
  localparam int LINE_YW = 10;

  typedef struct packed {
    logic [LINE_XW-1:0] x0;
    logic [LINE_XW-1:0] x1;
    logic [LINE_YW-1:0] y0;
    logic [LINE_YW-1:0] y1;
  } line_seg_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } sched_st_t;

endpackage

// File: rtl/line_job_sched_fifo.sv
// Segment FIFO. A pop frees its slot in the same cycle, so push is allowed while full if popping.
module line_seg_fifo
  import line_job_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     iCLK,
  input  logic                     iRST_n,
  input  logic                     push,
  input  line_seg_t                din,
  input  logic                     pop,
  output line_seg_t                dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  line_seg_t        mem_q [DEPTH];
  line_seg_t        mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/line_job_sched.sv
// Round-robin front end, job FIFO and launch FSM feeding the shared Bresenham line engine.
// Handshake: a segment transfers when req_valid[i] & req_ready[i]; req_ready is one-hot or zero.
module line_job_sched
  import line_job_sched_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int DEPTH   = 4,
  parameter int XW      = LINE_XW,
  parameter int YW      = LINE_YW,
  parameter int TIMEOUT = 4095
) (
  input  logic                     iCLK,
  input  logic                     iRST_n,
  input  logic                     launch_en,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  line_seg_t [N_REQ-1:0]    req_seg,
  output logic                     ln_start,
  output logic [XW-1:0]            ln_x0,
  output logic [XW-1:0]            ln_x1,
  output logic [YW-1:0]            ln_y0,
  output logic [YW-1:0]            ln_y1,
  input  logic                     ln_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              jobs_done,
  output logic                     timeout_err,
  input  logic                     err_clr,
  output sched_st_t                dbg_state
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PW-1:0] gnt_idx;
  logic          grant;
  logic          pop, can_accept;
  int            idx;
  line_seg_t     fifo_head;
  logic          fifo_full, fifo_empty;

  sched_st_t     state_q, state_d;
  logic          ln_start_q, ln_start_d;
  line_seg_t     seg_q, seg_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          aborted_q, aborted_d;
  logic [15:0]   jobs_q, jobs_d;
  logic          terr_q, terr_d;
  logic          abort_set;

  assign pop        = (state_q == ST_IDLE) && !fifo_empty && launch_en;
  assign can_accept = !fifo_full || pop;

  // Winner search starts at rr_ptr and wraps; at most one grant per cycle.
  always_comb begin
    req_ready = '0;
    grant     = 1'b0;
    gnt_idx   = rr_ptr_q;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!grant && can_accept && req_valid[idx]) begin
        grant   = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
    if (grant) begin
      req_ready[gnt_idx] = 1'b1;
    end
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  line_seg_fifo #(.DEPTH(DEPTH)) u_fifo (
    .iCLK   (iCLK),
    .iRST_n (iRST_n),
    .push   (grant),
    .din    (req_seg[gnt_idx]),
    .pop    (pop),
    .dout   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Watchdog is zero in LOAD and reads n in the n-th RUN cycle.
  always_comb begin
    state_d    = state_q;
    ln_start_d = 1'b0;
    seg_d      = seg_q;
    wd_d       = wd_q;
    aborted_d  = aborted_q;
    jobs_d     = jobs_q;
    abort_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d    = ST_LOAD;
          ln_start_d = 1'b1;
          seg_d      = fifo_head;
          wd_d       = '0;
          aborted_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        state_d = ST_RUN;
        wd_d    = wd_q + 1'b1;
      end
      ST_RUN: begin
        if (ln_done) begin
          state_d = ST_DONE;
        end else if (wd_q == WW'(TIMEOUT)) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
          abort_set = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (!aborted_q) begin
          jobs_d = jobs_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    terr_d = err_clr ? 1'b0 : (terr_q | abort_set);
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      ln_start_q <= 1'b0;
      seg_q      <= '0;
      wd_q       <= '0;
      aborted_q  <= 1'b0;
      jobs_q     <= '0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      ln_start_q <= ln_start_d;
      seg_q      <= seg_d;
      wd_q       <= wd_d;
      aborted_q  <= aborted_d;
      jobs_q     <= jobs_d;
      terr_q     <= terr_d;
    end
  end

  assign ln_start    = ln_start_q;
  assign ln_x0       = XW'(seg_q.x0);
  assign ln_x1       = XW'(seg_q.x1);
  assign ln_y0       = YW'(seg_q.y0);
  assign ln_y1       = YW'(seg_q.y1);
  assign busy        = (state_q != ST_IDLE) || !fifo_empty;
  assign jobs_done   = jobs_q;
  assign timeout_err = terr_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_line_job_sched.sv
// Directed bench for line_job_sched: default-timeout instance plus a TIMEOUT=15 instance.
module tb_line_job_sched;
  import line_job_sched_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A (default TIMEOUT) ----------------
  logic                 launch_en, ln_done, err_clr;
  logic [1:0]           req_valid, req_ready;
  line_seg_t [1:0]      req_seg;
  logic                 ln_start, busy, timeout_err;
  logic [LINE_XW-1:0]   ln_x0, ln_x1;
  logic [LINE_YW-1:0]   ln_y0, ln_y1;
  logic [2:0]           fifo_count;
  logic [15:0]          jobs_done;
  sched_st_t            dbg_state;

  line_job_sched dut (
    .iCLK(clk), .iRST_n(rst_n), .launch_en(launch_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_seg(req_seg),
    .ln_start(ln_start), .ln_x0(ln_x0), .ln_x1(ln_x1), .ln_y0(ln_y0), .ln_y1(ln_y1),
    .ln_done(ln_done), .busy(busy), .fifo_count(fifo_count), .jobs_done(jobs_done),
    .timeout_err(timeout_err), .err_clr(err_clr), .dbg_state(dbg_state)
  );

  // ---------------- instance B (TIMEOUT = 15) ----------------
  logic                 b_launch, b_done, b_eclr;
  logic [1:0]           b_valid, b_ready;
  line_seg_t [1:0]      b_seg;
  logic                 b_start, b_busy, b_terr;
  logic [LINE_XW-1:0]   b_x0, b_x1;
  logic [LINE_YW-1:0]   b_y0, b_y1;
  logic [2:0]           b_cnt;
  logic [15:0]          b_jobs;
  sched_st_t            b_state;

  line_job_sched #(.TIMEOUT(15)) dut_to (
    .iCLK(clk), .iRST_n(rst_n), .launch_en(b_launch),
    .req_valid(b_valid), .req_ready(b_ready), .req_seg(b_seg),
    .ln_start(b_start), .ln_x0(b_x0), .ln_x1(b_x1), .ln_y0(b_y0), .ln_y1(b_y1),
    .ln_done(b_done), .busy(b_busy), .fifo_count(b_cnt), .jobs_done(b_jobs),
    .timeout_err(b_terr), .err_clr(b_eclr), .dbg_state(b_state)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic line_seg_t mk_seg(input int x0, input int x1, input int y0, input int y1);
    line_seg_t s;
    s.x0 = LINE_XW'(x0);
    s.x1 = LINE_XW'(x1);
    s.y0 = LINE_YW'(y0);
    s.y1 = LINE_YW'(y1);
    return s;
  endfunction

  // Waits (bounded) for ln_start on instance A, checks endpoints, then completes the job.
  task automatic do_job(input string tag, input line_seg_t exp);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (ln_start) seen = 1'b1;
      else tick();
    end
    check({tag, "_start"}, 64'(seen), 64'd1);
    check({tag, "_seg"}, 64'({ln_x0, ln_x1, ln_y0, ln_y1}), 64'(exp));
    tick();
    ln_done = 1'b1;
    tick();
    ln_done = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  line_seg_t s_a, s_b, s_c, s_d, s_e, s_f;

  initial begin
    rst_n = 1'b0;
    launch_en = 1'b0; ln_done = 1'b0; err_clr = 1'b0; req_valid = '0; req_seg = '0;
    b_launch = 1'b0;  b_done = 1'b0;  b_eclr = 1'b0;  b_valid = '0;   b_seg = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_start", 64'(ln_start), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_jobs",  64'(jobs_done), 64'd0);
    check("rst_terr",  64'(timeout_err), 64'd0);
    check("rst_seg",   64'({ln_x0, ln_x1, ln_y0, ln_y1}), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1. single job, push -> ln_start two cycles later
    s_a = mk_seg(10, 200, 5, 90);
    launch_en = 1'b1;
    req_valid = 2'b01;
    req_seg[0] = s_a;
    #1;
    check("t1_ready", 64'(req_ready), 64'b01);
    tick();
    req_valid = 2'b00;
    check("t1_start_t1", 64'(ln_start), 64'd0);
    check("t1_count", 64'(fifo_count), 64'd1);
    tick();
    check("t1_start_t2", 64'(ln_start), 64'd1);
    check("t1_seg", 64'({ln_x0, ln_x1, ln_y0, ln_y1}), 64'(s_a));
    tick();
    check("t1_start_pulse", 64'(ln_start), 64'd0);
    check("t1_run", 64'(dbg_state), 64'(ST_RUN));
    repeat (49) tick();
    ln_done = 1'b1;
    tick();
    ln_done = 1'b0;
    tick();
    check("t1_jobs", 64'(jobs_done), 64'd1);
    check("t1_busy", 64'(busy), 64'd0);
    check("t1_hold", 64'({ln_x0, ln_x1, ln_y0, ln_y1}), 64'(s_a));

    // 2. contention: rr pointer is 1 after the grant to requester 0
    s_b = mk_seg(1, 2, 3, 4);
    s_c = mk_seg(5, 6, 7, 8);
    launch_en = 1'b0;
    req_seg[0] = s_b;
    req_seg[1] = s_c;
    req_valid = 2'b11;
    #1;
    check("t2_g0", 64'(req_ready), 64'b10);
    tick();
    check("t2_g1", 64'(req_ready), 64'b01);
    tick();
    check("t2_g2", 64'(req_ready), 64'b10);
    tick();
    check("t2_g3", 64'(req_ready), 64'b01);
    tick();
    check("t2_full_ready", 64'(req_ready), 64'b00);
    check("t2_full_count", 64'(fifo_count), 64'd4);
    tick();
    check("t2_full_ready2", 64'(req_ready), 64'b00);

    // 5. full FIFO, launch_en rises while req1 valid: pop and push together
    launch_en = 1'b1;
    #1;
    check("t5_ready", 64'(req_ready), 64'b10);
    tick();
    req_valid = 2'b00;
    check("t5_count", 64'(fifo_count), 64'd4);
    check("t5_load", 64'(dbg_state), 64'(ST_LOAD));
    check("t5_start", 64'(ln_start), 64'd1);
    check("t5_seg", 64'({ln_x0, ln_x1, ln_y0, ln_y1}), 64'(s_c));
    tick();
    ln_done = 1'b1;
    tick();
    ln_done = 1'b0;
    tick();
    do_job("t2_j1", s_b);
    do_job("t2_j2", s_c);
    do_job("t2_j3", s_b);
    do_job("t2_j4", s_c);
    check("t2_jobs", 64'(jobs_done), 64'd6);
    check("t2_busy", 64'(busy), 64'd0);

    // 3. gating with launch_en low, then FIFO-order launch (s_f is degenerate)
    s_d = mk_seg(100, 20, 300, 4);
    s_e = mk_seg(2047, 0, 0, 1023);
    s_f = mk_seg(7, 7, 3, 3);
    launch_en = 1'b0;
    req_valid = 2'b01;
    req_seg[0] = s_d;
    #1;
    check("t3_r0", 64'(req_ready), 64'b01);
    tick();
    req_seg[0] = s_e;
    tick();
    req_seg[0] = s_f;
    tick();
    req_valid = 2'b00;
    repeat (3) tick();
    check("t3_count", 64'(fifo_count), 64'd3);
    check("t3_nostart", 64'(ln_start), 64'd0);
    check("t3_idle", 64'(dbg_state), 64'(ST_IDLE));
    check("t3_busy", 64'(busy), 64'd1);
    launch_en = 1'b1;
    do_job("t3_j1", s_d);
    do_job("t3_j2", s_e);
    do_job("t3_j3", s_f);
    check("t3_jobs", 64'(jobs_done), 64'd9);
    ln_done = 1'b1;
    tick();
    ln_done = 1'b0;
    tick();
    check("t3_stray_done_jobs", 64'(jobs_done), 64'd9);
    check("t3_stray_done_state", 64'(dbg_state), 64'(ST_IDLE));

    // 4. watchdog on the TIMEOUT=15 instance: DONE 16 cycles after ln_start
    b_launch = 1'b1;
    b_valid = 2'b01;
    b_seg[0] = mk_seg(100, 300, 20, 40);
    tick();
    b_valid = 2'b00;
    tick();
    check("t4_start", 64'(b_start), 64'd1);
    repeat (15) tick();
    check("t4_run15", 64'(b_state), 64'(ST_RUN));
    check("t4_terr_pre", 64'(b_terr), 64'd0);
    tick();
    check("t4_done16", 64'(b_state), 64'(ST_DONE));
    check("t4_terr", 64'(b_terr), 64'd1);
    tick();
    check("t4_jobs", 64'(b_jobs), 64'd0);
    check("t4_terr_sticky", 64'(b_terr), 64'd1);
    b_eclr = 1'b1;
    tick();
    b_eclr = 1'b0;
    check("t4_clr", 64'(b_terr), 64'd0);

    // 6. asynchronous reset while a job runs and one is queued
    req_valid = 2'b01;
    req_seg[0] = s_a;
    tick();
    req_seg[0] = s_b;
    #1;
    check("t6_ready2", 64'(req_ready), 64'b01);
    tick();
    req_valid = 2'b00;
    check("t6_start", 64'(ln_start), 64'd1);
    tick();
    check("t6_run", 64'(dbg_state), 64'(ST_RUN));
    check("t6_count_pre", 64'(fifo_count), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_start_rst", 64'(ln_start), 64'd0);
    check("t6_busy_rst", 64'(busy), 64'd0);
    check("t6_count_rst", 64'(fifo_count), 64'd0);
    check("t6_state_rst", 64'(dbg_state), 64'(ST_IDLE));
    check("t6_jobs_rst", 64'(jobs_done), 64'd0);
    check("t6_seg_rst", 64'({ln_x0, ln_x1, ln_y0, ln_y1}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
